alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
Parameters:
REQ-001 XLEN, 64, datapath width; legal values 32 and 64.
REQ-002 SHIFT_STEP, 8, maximum bit positions shifted per cycle; power of two, 1..XLEN.
Ports:
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 flush  input  1  discard the operation in flight; synchronous.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  request accepted when in_valid && in_ready.
REQ-008 op_type  input  16  one-hot op select: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, L=8, LU=9, EQ=10, NE=11, GE=12, GEU=13, LUI=14, AUIPC=15.
REQ-009 op0  input  XLEN  first operand (pc for AUIPC).
REQ-010 op1  input  XLEN  second operand / immediate / shift amount.
REQ-011 is_word_op  input  1  32-bit word-op modifier; exists only with ALU_WORD_OP_EN.
REQ-012 out_valid  output  1  alu_res valid.
REQ-013 out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-014 alu_res  output  XLEN  result, registered.
REQ-015 busy  output  1  high in SHIFT or DONE.

Function
REQ-016 States IDLE, SHIFT, DONE; in_ready = (IDLE) || (DONE && out_ready); out_valid = (DONE); busy = (state != IDLE).
REQ-017 Accept of a non-shift op, or of a shift op with shamt 0: state -> DONE, alu_res loaded with the result next edge (latency 1).
REQ-018 Accept of SLL/SRL/SRA with shamt != 0: operand and remaining count latched, state -> SHIFT.
REQ-019 Each SHIFT cycle shifts by min(remaining, SHIFT_STEP) and decrements remaining accordingly; at remaining 0 -> DONE with the final value; total latency 1 + ceil(shamt/SHIFT_STEP).
REQ-020 shamt = op1[log2(XLEN)-1:0]; SRA fills with the operand sign bit; SRL and SLL fill with 0.
REQ-021 ADD/AUIPC = op0+op1, SUB = op0-op1, modulo 2^XLEN; AND/OR/XOR bitwise; LUI = op1.
REQ-022 L/LU/EQ/NE/GE/GEU yield 1 when true (signed <, unsigned <, ==, !=, signed >=, unsigned >=), else 0.
REQ-023 op_type zero or multi-hot: result 0, latency 1, no SHIFT state.
REQ-024 DONE holds alu_res stable until out_ready; a DONE handshake plus a simultaneous accept starts the new op with no bubble cycle.
REQ-025 A DONE handshake with no new accept -> IDLE.
REQ-026 flush forces IDLE next edge from any state, drops the held result, and suppresses any accept in that cycle (in_ready is 0 while flush is high).

Reset
REQ-027 rst forces IDLE next edge, from any state including mid-SHIFT; out_valid=0, busy=0, alu_res=0, internal count=0.
REQ-028 in_ready = 1 in the first cycle after reset deasserts.
REQ-029 rst has priority over flush and over handshakes.

Configuration
REQ-030 Macro ALU_WORD_OP_EN.
With the macro: is_word_op port exists and, when XLEN=64 and is_word_op=1:
- ADD, SUB, SLL, SRL and SRA use the low 32 bits.
- shamt = op1[4:0].
- SRL and SRA shift op0[31:0]; SRA fills with bit 31.
- The result is sign-extended from bit 31.
- All other ops ignore is_word_op.
With XLEN=32, is_word_op is ignored.
REQ-031 Without the macro: no is_word_op port; all ops are full XLEN.

Verification
REQ-032 XLEN=64, SHIFT_STEP=8: SLL op0=1, op1=63, out_ready=1 -> out_valid exactly 9 cycles after accept, alu_res=0x8000000000000000.
REQ-033 SRA op0=0x8000000000000000, op1=4 -> alu_res=0xF800000000000000 after 2 cycles; shamt 0 -> op0 unchanged after 1 cycle.
REQ-034 Back-to-back ADD 5+7 then LU 1<0xFFFFFFFFFFFFFFFF, out_ready=1 -> results 12 then 1 on consecutive cycles; hold out_ready=0 for 3 cycles -> alu_res and out_valid stable, in_ready=0.
REQ-035 rst asserted during the 4th SHIFT cycle -> next cycle state IDLE, out_valid=0, alu_res=0; flush in DONE -> result dropped, in_ready=1 the next cycle.
REQ-036 ALU_WORD_OP_EN, is_word_op=1: ADD op0=0x7FFFFFFF, op1=1 -> 0xFFFFFFFF80000000; SRL op0=0xFFFFFFFF00000010, op1=4 -> 0x1; op_type=0x0003 -> alu_res=0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a stepped barrel shifter and valid/ready handshakes.
// Ports: clk, rst (sync active-high), flush (drop in-flight op),
//        in_valid/in_ready/op_type/op0/op1 request side,
//        out_valid/out_ready/alu_res result side, busy (SHIFT or DONE).
// Optional macro ALU_WORD_OP_EN adds is_word_op (32-bit word ops when XLEN=64).
module alu_seq #(
    parameter int XLEN       = 64,
    parameter int SHIFT_STEP = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     op_type,
    input  logic [XLEN-1:0] op0,
    input  logic [XLEN-1:0] op1,
`ifdef ALU_WORD_OP_EN
    input  logic            is_word_op,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_res,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] res, res_n, sh_val, sh_val_n;
    logic [CW-1:0]   cnt, cnt_n, step;
    logic [1:0]      sh_op, sh_op_n;
    logic            sh_word, sh_word_n;
    logic            wop, one_hot, is_shift, accept;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] sum, diff, imm_res, sh_init, sh_next;

`ifdef ALU_WORD_OP_EN
    assign wop = is_word_op && (XLEN == 64);
`else
    assign wop = 1'b0;
`endif

    // Replace bits above 31 with s & x[31]: s=1 sign-extends, s=0 zero-extends.
    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] x, input logic s);
        ext32 = x;
        for (int i = 32; i < XLEN; i++) ext32[i] = s & x[31];
    endfunction

    assign one_hot  = (op_type != '0) && ((op_type & (op_type - 16'd1)) == '0);
    assign is_shift = one_hot && (op_type[7:5] != '0);
    assign shamt    = op1[SW-1:0] & (wop ? SW'(31) : '1);
    assign in_ready = !flush && (state == IDLE || (state == DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign sum      = op0 + op1;
    assign diff     = op0 - op1;

    // The final branch is only reached by a shift op with shamt 0.
    assign imm_res = !one_hot    ? '0 :
                     op_type[0]  ? (wop ? ext32(sum, 1'b1) : sum) :
                     op_type[1]  ? (wop ? ext32(diff, 1'b1) : diff) :
                     op_type[2]  ? op0 & op1 :
                     op_type[3]  ? op0 | op1 :
                     op_type[4]  ? op0 ^ op1 :
                     op_type[8]  ? XLEN'($signed(op0) < $signed(op1)) :
                     op_type[9]  ? XLEN'(op0 < op1) :
                     op_type[10] ? XLEN'(op0 == op1) :
                     op_type[11] ? XLEN'(op0 != op1) :
                     op_type[12] ? XLEN'($signed(op0) >= $signed(op1)) :
                     op_type[13] ? XLEN'(op0 >= op1) :
                     op_type[14] ? op1 :
                     op_type[15] ? sum :
                     (wop ? ext32(op0, 1'b1) : op0);

    // Word shifts run on a pre-extended operand so the full-width shifter
    // produces the correct low 32 bits (SRA fill comes from bit 31).
    assign sh_init = wop ? ext32(op0, op_type[7]) : op0;
    assign step    = (cnt > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : cnt;
    assign sh_next = sh_op[0] ? sh_val << step :
                     sh_op[1] ? sh_val >> step :
                     $unsigned($signed(sh_val) >>> step);

    always_comb begin
        state_n   = state;
        res_n     = res;
        cnt_n     = cnt;
        sh_val_n  = sh_val;
        sh_op_n   = sh_op;
        sh_word_n = sh_word;
        if (flush) begin
            state_n = IDLE;
            res_n   = '0;
            cnt_n   = '0;
        end else if (state == SHIFT) begin
            sh_val_n = sh_next;
            cnt_n    = cnt - step;
            if (cnt == step) begin
                state_n = DONE;
                res_n   = sh_word ? ext32(sh_next, 1'b1) : sh_next;
            end
        end else if (accept) begin
            if (is_shift && shamt != '0) begin
                state_n   = SHIFT;
                sh_val_n  = sh_init;
                cnt_n     = CW'(shamt);
                sh_op_n   = op_type[6:5];
                sh_word_n = wop;
            end else begin
                state_n = DONE;
                res_n   = imm_res;
            end
        end else if (state == DONE && out_ready) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            res     <= '0;
            cnt     <= '0;
            sh_val  <= '0;
            sh_op   <= '0;
            sh_word <= 1'b0;
        end else begin
            state   <= state_n;
            res     <= res_n;
            cnt     <= cnt_n;
            sh_val  <= sh_val_n;
            sh_op   <= sh_op_n;
            sh_word <= sh_word_n;
        end
    end

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign alu_res   = res;
endmodule
